// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioner: synchronize, debounce, count arrivals, hold SENSOR until served, flag long waits.
// Optional loop-stuck detection is enabled by defining VEHICLE_SENSOR_STUCK_DET_EN.
module vehicle_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned MAX_WAIT        = 240,
  parameter int unsigned WAIT_W          = 8,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             served,
  output logic             SENSOR,
  output logic             arrival,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             urgent,
  output logic             stuck_fault
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    URGENT  = 2'd2
  } state_t;

  logic              sync1;
  logic              sync2;
  logic              db_state;
  logic              db_state_q;
  logic [DB_W-1:0]   db_cnt;
  logic              stuck;
  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  // Level changes only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_state   <= 1'b0;
      db_state_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_state_q <= db_state;
      if (sync2 != db_state) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_state <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign arrival = db_state & ~db_state_q;

`ifdef VEHICLE_SENSOR_STUCK_DET_EN
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);

  logic [STK_W-1:0] stuck_cnt;

  // Sticky fault once the debounced level has stayed high too long
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end else if (db_state) begin
      if (stuck_cnt != STK_W'(STUCK_CYCLES)) begin
        stuck_cnt <= stuck_cnt + STK_W'(1);
      end
      if (stuck_cnt >= STK_W'(STUCK_CYCLES - 1)) begin
        stuck <= 1'b1;
      end
    end else begin
      stuck_cnt <= '0;
    end
  end
`else
  logic unused_stuck_cycles;
  assign unused_stuck_cycles = (STUCK_CYCLES == 0);
  assign stuck = 1'b0;
`endif

  // Waiting-vehicle count; a vehicle arriving on the serve cycle is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_cnt <= '0;
    end else if (!stuck) begin
      if (served && arrival) begin
        queue_cnt <= CNT_W'(1);
      end else if (served) begin
        queue_cnt <= '0;
      end else if (arrival && (queue_cnt != {CNT_W{1'b1}})) begin
        queue_cnt <= queue_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Request FSM with saturating wait timer
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (arrival) begin
          state_nxt = PENDING;
          wait_nxt  = '0;
        end
      end
      PENDING: begin
        if (served) begin
          state_nxt = arrival ? PENDING : IDLE;
          wait_nxt  = '0;
        end else begin
          if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
          if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) begin
            state_nxt = URGENT;
          end
        end
      end
      URGENT: begin
        if (served) begin
          state_nxt = arrival ? PENDING : IDLE;
          wait_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  assign SENSOR      = stuck | (state != IDLE);
  assign urgent      = ~stuck & (state == URGENT);
  assign stuck_fault = stuck;

endmodule

// File: doc/vehicle_sensor_conditioner.md
Name: vehicle_sensor_conditioner

Overview:
Upstream stage of the traffic light signal generator. Takes the raw, asynchronous, bouncy east-west loop-detector input and produces the clean SENSOR request the signal generator samples while NS is green. Counts waiting vehicles, holds the request until the controller reports the EW phase served, and raises an urgent flag if a request waits too long.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples of the new level required before the debounced level changes (>=1)
CNT_W, 4, width of the waiting-vehicle counter
MAX_WAIT, 240, cycles a pending request may wait before urgent asserts (two 120-cycle timing-counter periods)
WAIT_W, 8, width of the wait timer; must hold MAX_WAIT
STUCK_CYCLES, 1000, continuous debounced-high cycles that declare the loop stuck (optional feature only)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sensor_raw  input  1  raw loop-detector level, asynchronous to clk
served  input  1  single-cycle pulse from the controller when EW green begins; clears the pending request
SENSOR  output  1  vehicle-waiting request to the signal generator
arrival  output  1  one-cycle pulse per debounced vehicle arrival
queue_cnt  output  CNT_W  vehicles waiting since the last serve
urgent  output  1  request has waited >= MAX_WAIT cycles
stuck_fault  output  1  sticky loop-stuck fault (feature-dependent)

Behaviour:
- Reset (async, rst=1): both sync flops, db_state, db_cnt, queue_cnt, wait_cnt and FSM cleared. SENSOR=0, arrival=0, queue_cnt=0, urgent=0, stuck_fault=0, FSM=IDLE.
- Synchronizer: 2 flops; sensor_sync = second stage.
- Debounce: if sensor_sync != db_state, db_cnt increments. On the DEBOUNCE_CYCLES-th consecutive differing sample, db_state <= sensor_sync and db_cnt <= 0. Any sample equal to db_state clears db_cnt. Raw-to-db_state latency is 2+DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- arrival = db_state & ~db_state_q. High only in the first cycle db_state reads 1. Falling edges produce nothing.
- queue_cnt: +1 on arrival, saturating at 2^CNT_W-1. Cleared on served. If arrival and served occur in the same cycle, queue_cnt <= 1 and wait_cnt <= 0, so the new vehicle is kept.
- FSM states: IDLE (queue_cnt==0), PENDING, URGENT.
  - IDLE -> PENDING on arrival.
  - PENDING: wait_cnt increments each cycle, saturating at MAX_WAIT. -> URGENT when wait_cnt reaches MAX_WAIT. -> IDLE on served without arrival.
  - URGENT: -> IDLE on served without arrival. Served with arrival -> PENDING.
  - served while in IDLE: ignored.
- Outputs are registered-state decodes:
  - SENSOR = (state != IDLE).
  - urgent = (state == URGENT).
  - SENSOR rises the cycle after the arrival pulse.
- Reset asserted mid-operation: everything returns to reset values immediately, regardless of the pending queue.

Optional Feature:
- Macro: VEHICLE_SENSOR_STUCK_DET_EN.
- When defined:
  - A counter runs while db_state==1 and clears when db_state==0.
  - On reaching STUCK_CYCLES, stuck_fault sets and stays set until rst.
  - While stuck_fault=1: SENSOR forced 1 (fail-safe, EW is always served), urgent forced 0, queue_cnt frozen.
- When not defined: no counter logic; stuck_fault tied 0; port still present.

Test Plan:
- Reset release with sensor_raw=0 for 50 cycles -> SENSOR=0, queue_cnt=0, urgent=0, no arrival pulses.
- sensor_raw high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> no arrival, queue_cnt stays 0.
- sensor_raw 0->1 held -> arrival pulses exactly once at cycle 6 after the edge. SENSOR=1 at cycle 7. queue_cnt=1.
- Three clean pulses (each 10 cycles high, 10 low), then a served pulse -> queue_cnt 1,2,3, then 0. SENSOR drops the cycle after served.
- One arrival, no served for 240 cycles -> urgent=1 exactly when wait_cnt hits 240. A served pulse returns to urgent=0, SENSOR=0.
- 20 arrivals with CNT_W=4 -> queue_cnt saturates at 15. Arrival coincident with served -> queue_cnt=1, SENSOR stays 1, wait_cnt=0.
- With VEHICLE_SENSOR_STUCK_DET_EN and STUCK_CYCLES=1000, sensor_raw held high -> stuck_fault=1 and SENSOR=1 persist after sensor_raw drops, until rst.
